// File: rtl/uart_tx_if.sv
// uart_tx_if: FIFO-side handshake and serial outputs of the UART transmitter.
// The master modport is the FIFO/system side, the slave modport is uart_tx.
interface uart_tx_if #(
   parameter int unsigned DataWidth = 8
);
   logic                 i_fifo_empty;
   logic [DataWidth-1:0] i_fifo_data;
   logic                 o_fifo_rd;
   logic                 o_tx;
   logic                 o_busy;

   modport master (
      output i_fifo_empty,
      output i_fifo_data,
      input  o_fifo_rd,
      input  o_tx,
      input  o_busy
   );

   modport slave (
      input  i_fifo_empty,
      input  i_fifo_data,
      output o_fifo_rd,
      output o_tx,
      output o_busy
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: drains an async-read TX FIFO and serialises each word LSB-first as
// start bit, DataWidth data bits, optional even parity, StopBits stop bits.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int unsigned DataWidth  = 8,
   parameter int unsigned ClksPerBit = 868,
   parameter int unsigned StopBits   = 1
) (
   input  logic     i_clk,
   input  logic     i_rst,
   uart_tx_if.slave bus
);

   localparam int unsigned BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam int unsigned BitW  = $clog2(DataWidth + 1);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(DataWidth - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] StParity = 3'd3;
`endif
   localparam logic [2:0] StStop   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [BaudW-1:0]     baud_q, baud_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif
   logic                 baud_last;
   logic                 last_stop;
   logic                 pop;

   // Next-state, pop strobe and registered-output decode for the frame FSM.
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      tx_d      = 1'b1;
      busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      baud_last = (baud_q == BaudLast);
      last_stop = (state_q == StStop) && baud_last && (bit_q == StopLast);
      pop       = ((state_q == StIdle) || last_stop) && !bus.i_fifo_empty && !i_rst;
      baud_d    = ((state_q == StIdle) || baud_last) ? '0 : baud_q + 1'b1;

      case (state_q)
         StIdle: ;
         StStart: begin
            if (baud_last) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == DataLast) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_last) begin
               state_d = StStop;
               bit_d   = '0;
            end
         end
`endif
         StStop: begin
            if (baud_last) begin
               if (bit_q == StopLast) begin
                  bit_d   = '0;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // pop is only possible in IDLE or the final stop cycle, so a single
      // capture here covers both the idle start and the back-to-back start.
      if (pop) begin
         state_d = StStart;
         shift_d = bus.i_fifo_data;
         bit_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^bus.i_fifo_data;
`endif
      end

      case (state_d)
         StIdle: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // State, counters, shift register and registered line outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.o_fifo_rd = pop;
   assign bus.o_tx      = tx_q;
   assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven plus directed checks of uart_tx with a FIFO model
// and a byte scoreboard decoded from the serial line.
module tb_uart_tx;

   localparam int unsigned CPB  = 4;
   localparam int unsigned CPB1 = 3;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned PB = 1;
`else
   localparam int unsigned PB = 0;
`endif
   localparam int unsigned FL0       = 1 + 8 + PB + 1;
   localparam int unsigned FRAME_CYC = FL0 * CPB;
   localparam int unsigned FL1       = 1 + 8 + PB + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_if #(.DataWidth(8)) if0 ();
   uart_tx_if #(.DataWidth(8)) if1 ();

   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .StopBits(1)) u0 (
      .i_clk(clk), .i_rst(rst), .bus(if0)
   );
   uart_tx #(.DataWidth(8), .ClksPerBit(CPB1), .StopBits(2)) u1 (
      .i_clk(clk), .i_rst(rst), .bus(if1)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [11:0] build(logic [7:0] d);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^d;
`endif
      return f;
   endfunction

   // FIFO model for u0: async read of head, pop on the rd strobe.
   logic [7:0] mem0 [16];
   logic [7:0] wr0 = '0;
   logic [7:0] rd0 = '0;
   assign if0.i_fifo_empty = (wr0 == rd0);
   assign if0.i_fifo_data  = mem0[rd0[3:0]];
   always @(posedge clk) if (if0.o_fifo_rd) rd0 <= rd0 + 1'b1;

   // Single-word FIFO model for u1.
   logic [7:0] wr1 = '0;
   logic [7:0] rd1 = '0;
   logic [7:0] d1  = '0;
   assign if1.i_fifo_empty = (wr1 == rd1);
   assign if1.i_fifo_data  = d1;
   always @(posedge clk) if (if1.o_fifo_rd) rd1 <= rd1 + 1'b1;

   logic [7:0] sb0 [$];

   task automatic push0(input logic [7:0] b);
      mem0[wr0[3:0]] = b;
      wr0 = wr0 + 1'b1;
      sb0.push_back(b);
   endtask

   // Line monitor for u0.
   int unsigned cyc = 0, pops0 = 0, pops1 = 0, busy0 = 0, frames0 = 0, aborts0 = 0, viol = 0;
   int unsigned pop_cyc = 0, start_cyc = 0, prev_start = 0, mcyc = 0, nmis = 0;
   bit          inframe = 1'b0;
   logic [11:0] mframe;
   logic [7:0]  rx = '0, last_rx = '0;
   logic        rxpar = 1'b0, last_par = 1'b0;

   always @(posedge clk) begin
      int unsigned bi;
      if (if0.o_fifo_rd === 1'b1) begin
         pops0++;
         pop_cyc = cyc;
      end
      if (if1.o_fifo_rd === 1'b1) pops1++;
      if ((if0.o_fifo_rd === 1'b1 && if0.i_fifo_empty) || (if1.o_fifo_rd === 1'b1 && if1.i_fifo_empty))
         viol++;
      cyc++;
      #1;
      if (if0.o_busy === 1'b1) busy0++;
      if (rst) begin
         if (inframe) aborts0++;
         inframe = 1'b0;
      end else begin
         if (!inframe && if0.o_tx === 1'b0) begin
            prev_start = start_cyc;
            start_cyc  = cyc;
            mcyc       = 0;
            nmis       = 0;
            inframe    = 1'b1;
            if (sb0.size() > 0) mframe = build(sb0.pop_front());
            else                mframe = '1;
         end
         if (inframe) begin
            if (if0.o_tx !== mframe[mcyc / CPB] || if0.o_busy !== 1'b1) nmis++;
            if (mcyc % CPB == CPB / 2) begin
               bi = mcyc / CPB;
               if (bi >= 1 && bi <= 8) rx[bi-1] = if0.o_tx;
               if (bi == 9) rxpar = if0.o_tx;
            end
            mcyc++;
            if (mcyc == FRAME_CYC) begin
               check("frame_bits", nmis, 0);
               last_rx  = rx;
               last_par = rxpar;
               frames0++;
               inframe  = 1'b0;
            end
         end
      end
   end

   task automatic wait_frames0(input int unsigned target, input string nm);
      int unsigned n;
      n = 0;
      while (frames0 < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(nm, frames0, target);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   initial begin
      vec_t        tbl [5];
      int unsigned nb, p0, b0, f0, a0, p1, len, mis, n;
      bit          started;
      logic [11:0] e1;

      tbl[0] = '{8'hA5, 1'b0};
      tbl[1] = '{8'h07, 1'b1};
      tbl[2] = '{8'h03, 1'b0};
      tbl[3] = '{8'h80, 1'b1};
      tbl[4] = '{8'hFF, 1'b0};

      // Reset held 3 cycles with an empty FIFO, then 100 idle cycles.
      rst = 1'b1;
      nb  = 0;
      for (int i = 0; i < 103; i++) begin
         @(posedge clk);
         #2;
         if (if0.o_tx !== 1'b1 || if0.o_busy !== 1'b0 || if0.o_fifo_rd !== 1'b0) nb++;
         if (i == 2) begin
            @(negedge clk);
            rst = 1'b0;
         end
      end
      check("reset_idle", nb, 0);
      check("reset_tx", if0.o_tx, 1);

      // Single frames from the vector table.
      for (int i = 0; i < 5; i++) begin
         p0 = pops0;
         b0 = busy0;
         f0 = frames0;
         @(negedge clk);
         push0(tbl[i].data);
         wait_frames0(f0 + 1, "tbl_frame");
         repeat (3) @(negedge clk);
         check("tbl_data", last_rx, tbl[i].data);
`ifdef UART_TX_PARITY_EN
         check("tbl_par", last_par, tbl[i].par);
`endif
         check("tbl_busy", busy0 - b0, FRAME_CYC);
         check("tbl_pops", pops0 - p0, 1);
         check("tbl_latency", start_cyc - pop_cyc, 1);
      end

      // Back-to-back: second pop in final stop cycle, no idle gap.
      p0 = pops0;
      b0 = busy0;
      f0 = frames0;
      @(negedge clk);
      push0(8'h00);
      push0(8'hFF);
      wait_frames0(f0 + 2, "b2b_frames");
      repeat (3) @(negedge clk);
      check("b2b_pops", pops0 - p0, 2);
      check("b2b_busy", busy0 - b0, 2 * FRAME_CYC);
      check("b2b_gap", start_cyc - prev_start, FRAME_CYC);
      check("b2b_pop_at_stop", start_cyc - pop_cyc, 1);
      check("b2b_last", last_rx, 8'hFF);

      // Reset during data bit 3 of 0x5A, 0x3C queued behind it.
      p0 = pops0;
      f0 = frames0;
      a0 = aborts0;
      @(negedge clk);
      push0(8'h5A);
      push0(8'h3C);
      n = 0;
      while (!(inframe && mcyc == 18) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reached", mcyc, 18);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check("midrst_tx", if0.o_tx, 1);
      check("midrst_busy", if0.o_busy, 0);
      check("midrst_rd", if0.o_fifo_rd, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_frames0(f0 + 1, "midrst_frame");
      repeat (3) @(negedge clk);
      check("midrst_abort", aborts0 - a0, 1);
      check("midrst_next", last_rx, 8'h3C);
      check("midrst_pops", pops0 - p0, 2);

      // Two stop bits at 3 clocks per bit.
      p1 = pops1;
      e1 = build(8'h81);
      @(negedge clk);
      d1  = 8'h81;
      wr1 = wr1 + 1'b1;
      len = 0;
      mis = 0;
      started = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (if1.o_busy === 1'b1) begin
            started = 1'b1;
            if (len / CPB1 < 12) begin
               if (if1.o_tx !== e1[len / CPB1]) mis++;
            end else begin
               mis++;
            end
            len++;
         end else if (started) begin
            break;
         end
      end
      check("sb2_len", len, FL1 * CPB1);
      check("sb2_bits", mis, 0);
      check("sb2_idle_tx", if1.o_tx, 1);
      check("sb2_pops", pops1 - p1, 1);

      check("empty_pop", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
